bus_master_mux: RTL and testbench

Shared-bus front end for N bus masters. It sits on the slave side of fixed-priority request arbitration, where the lowest index wins. When the bus is idle it picks one requesting master and locks ownership to it until that master's transaction completes. It forwards the owner's address, write flag and write data to the single slave port and routes ack and read data back to the owner only. A watchdog counter ends stalled transactions with an error acknowledge.

---
 rtl/bus_master_mux.sv | 112 +++++++++++
 tb/tb_bus_master_mux.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_master_mux.sv
// Shared-bus front end: grants the lowest-index requesting master, locks
// ownership until that master's transaction ends, forwards its fields to the
// slave and returns ack / read data (or a watchdog error) to the owner only.
module bus_master_mux #(
    parameter int unsigned masters       = 2,
    parameter int unsigned addressWidth  = 32,
    parameter int unsigned dataWidth     = 32,
    parameter int unsigned timeoutCycles = 256
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [masters-1:0]                masterRequest,
    input  logic [masters-1:0]                masterWrite,
    input  logic [masters*addressWidth-1:0]   masterAddress,
    input  logic [masters*dataWidth-1:0]      masterWriteData,
    output logic [masters-1:0]                masterAck,
    output logic [masters-1:0]                masterError,
    output logic [dataWidth-1:0]              masterReadData,
    output logic                              slaveRequest,
    output logic                              slaveWrite,
    output logic [addressWidth-1:0]           slaveAddress,
    output logic [dataWidth-1:0]              slaveWriteData,
    input  logic                              slaveAck,
    input  logic [dataWidth-1:0]              slaveReadData
);

    localparam int unsigned TIMER_W = $clog2(timeoutCycles);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(timeoutCycles - 1);

    logic                 busy;
    logic                 busy_next;
    logic [masters-1:0]   owner;
    logic [masters-1:0]   owner_next;
    logic [TIMER_W-1:0]   timer;
    logic [TIMER_W-1:0]   timer_next;

    logic [masters-1:0]   lowest_request;
    logic                 owner_requesting;
    logic                 ack_hit;
    logic                 timeout_hit;

    // Lowest set request bit (two's-complement isolate)
    assign lowest_request   = masterRequest & (~masterRequest + masters'(1));
    // Owner still holding its request; dropping it aborts the transaction
    assign owner_requesting = |(masterRequest & owner);
    // Slave ack wins over a coinciding timeout
    assign ack_hit          = busy & owner_requesting & slaveAck;
    assign timeout_hit      = busy & owner_requesting & ~slaveAck & (timer == TIMER_LAST);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy  <= 1'b0;
            owner <= '0;
            timer <= '0;
        end else begin
            busy  <= busy_next;
            owner <= owner_next;
            timer <= timer_next;
        end
    end

    // Next state: grant from IDLE, release on ack / timeout / abort
    always_comb begin
        busy_next  = busy;
        owner_next = owner;
        timer_next = timer;
        if (!busy) begin
            if (|masterRequest) begin
                busy_next  = 1'b1;
                owner_next = lowest_request;
                timer_next = '0;
            end
        end else if (ack_hit || timeout_hit || !owner_requesting) begin
            busy_next  = 1'b0;
            owner_next = '0;
            timer_next = '0;
        end else begin
            timer_next = timer + TIMER_W'(1);
        end
    end

    // Outputs: owner mux toward the slave, one-hot strobes back to the owner
    always_comb begin
        slaveRequest   = busy & owner_requesting;
        slaveWrite     = 1'b0;
        slaveAddress   = '0;
        slaveWriteData = '0;
        masterAck      = '0;
        masterError    = '0;
        masterReadData = '0;
        if (busy) begin
            for (int unsigned i = 0; i < masters; i++) begin
                if (owner[i]) begin
                    slaveWrite     = masterWrite[i];
                    slaveAddress   = masterAddress[i*addressWidth +: addressWidth];
                    slaveWriteData = masterWriteData[i*dataWidth +: dataWidth];
                end
            end
        end
        if (ack_hit || timeout_hit) begin
            masterAck = owner;
        end
        if (timeout_hit) begin
            masterError = owner;
        end
        if (ack_hit) begin
            masterReadData = slaveReadData;
        end
    end

endmodule

// File: tb/tb_bus_master_mux.sv
// Bench for bus_master_mux: vector table of single transactions, scoreboard
// on the master return path, hand sequences for priority, abort and reset.
module tb_bus_master_mux;

    localparam int unsigned M  = 3;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned T  = 4;

    logic              clk;
    logic              reset;
    logic [M-1:0]      masterRequest;
    logic [M-1:0]      masterWrite;
    logic [M*AW-1:0]   masterAddress;
    logic [M*DW-1:0]   masterWriteData;
    logic [M-1:0]      masterAck;
    logic [M-1:0]      masterError;
    logic [DW-1:0]     masterReadData;
    logic              slaveRequest;
    logic              slaveWrite;
    logic [AW-1:0]     slaveAddress;
    logic [DW-1:0]     slaveWriteData;
    logic              slaveAck;
    logic [DW-1:0]     slaveReadData;

    bus_master_mux #(
        .masters(M), .addressWidth(AW), .dataWidth(DW), .timeoutCycles(T)
    ) dut (
        .clk(clk), .reset(reset),
        .masterRequest(masterRequest), .masterWrite(masterWrite),
        .masterAddress(masterAddress), .masterWriteData(masterWriteData),
        .masterAck(masterAck), .masterError(masterError),
        .masterReadData(masterReadData),
        .slaveRequest(slaveRequest), .slaveWrite(slaveWrite),
        .slaveAddress(slaveAddress), .slaveWriteData(slaveWriteData),
        .slaveAck(slaveAck), .slaveReadData(slaveReadData)
    );

    typedef struct {
        logic [M-1:0]  ack;
        logic [M-1:0]  err;
        logic [DW-1:0] rdata;
    } exp_t;

    typedef struct {
        int            m;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            ack_at;     // BUSY cycle of slave ack, 0 = never
        logic [DW-1:0] rdata;
        logic [M-1:0]  exp_ack;
        logic [M-1:0]  exp_err;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Scoreboard: every ack must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (masterAck != '0) begin
                if (sb.size() == 0) begin
                    check("unexpected_ack", 32'(masterAck), 32'h0);
                end else begin
                    e = sb.pop_front();
                    check("sb_ack", 32'(masterAck), 32'(e.ack));
                    check("sb_err", 32'(masterError), 32'(e.err));
                    check("sb_rdata", masterReadData, e.rdata);
                end
            end else begin
                check("idle_err", 32'(masterError), 32'h0);
                check("idle_rdata", masterReadData, 32'h0);
            end
        end
    end

    task automatic set_master(input int m, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        masterWrite[m]              = wr;
        masterAddress[m*AW +: AW]   = a;
        masterWriteData[m*DW +: DW] = d;
    endtask

    // One transaction from IDLE; entered and left at posedge+1
    task automatic run_vec(input vec_t v);
        int done_k;
        set_master(v.m, v.wr, v.addr, v.wdata);
        masterRequest[v.m] = 1'b1;
        sb.push_back('{v.exp_ack, v.exp_err, v.exp_rdata});
        @(negedge clk);
        check("grant_latency", 32'(slaveRequest), 32'h0);
        @(posedge clk); #1;
        done_k = (v.ack_at >= 1 && v.ack_at <= int'(T)) ? v.ack_at : int'(T);
        for (int k = 1; k <= done_k; k++) begin
            slaveAck      = (k == v.ack_at);
            slaveReadData = (k == v.ack_at) ? v.rdata : 32'hBAD0_0000 + 32'(k);
            @(negedge clk);
            check("slave_req", 32'(slaveRequest), 32'h1);
            check("slave_addr", slaveAddress, v.addr);
            check("slave_write", 32'(slaveWrite), 32'(v.wr));
            check("slave_wdata", slaveWriteData, v.wr ? v.wdata : slaveWriteData & 32'h0 | v.wdata);
            if (k < done_k) check("no_early_ack", 32'(masterAck), 32'h0);
            @(posedge clk); #1;
        end
        slaveAck           = 1'b0;
        slaveReadData      = '0;
        masterRequest[v.m] = 1'b0;
        @(negedge clk);
        check("idle_after_done", 32'(slaveRequest), 32'h0);
        check("idle_no_ack", 32'(masterAck), 32'h0);
        @(posedge clk); #1;
    endtask

    vec_t vecs[5];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        vecs[0] = '{1, 1'b0, 32'h0000_0100, 32'h0,         2, 32'hDEAD_BEEF, 3'b010, 3'b000, 32'hDEAD_BEEF};
        vecs[1] = '{0, 1'b1, 32'h0000_0200, 32'h1234_5678, 1, 32'h0,         3'b001, 3'b000, 32'h0};
        vecs[2] = '{2, 1'b0, 32'h0000_0300, 32'h0,         4, 32'hCAFE_F00D, 3'b100, 3'b000, 32'hCAFE_F00D};
        vecs[3] = '{0, 1'b0, 32'h0000_0400, 32'h0,         0, 32'h0,         3'b001, 3'b001, 32'h0};
        vecs[4] = '{2, 1'b1, 32'h0000_0500, 32'h0000_0055, 3, 32'h0000_0077, 3'b100, 3'b000, 32'h0000_0077};

        reset           = 1'b1;
        masterRequest   = '0;
        masterWrite     = '0;
        masterAddress   = '0;
        masterWriteData = '0;
        slaveAck        = 1'b0;
        slaveReadData   = '0;
        #2;
        check("reset_slave_req", 32'(slaveRequest), 32'h0);
        check("reset_ack", 32'(masterAck), 32'h0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_idle", 32'(slaveRequest), 32'h0);
        @(posedge clk); #1;

        // Table-driven single transactions (reads, writes, timeout, ack at timeout)
        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Priority and lock: 0 and 2 together, 1 arrives mid-transaction
        set_master(0, 1'b0, 32'hA000, 32'h0);
        set_master(1, 1'b0, 32'hA100, 32'h0);
        set_master(2, 1'b0, 32'hA200, 32'h0);
        masterRequest = 3'b101;
        @(posedge clk); #1;
        @(negedge clk);
        check("prio_owner0", slaveAddress, 32'hA000);
        @(posedge clk); #1;
        masterRequest[1] = 1'b1;
        @(negedge clk);
        check("lock_addr", slaveAddress, 32'hA000);
        check("lock_no_ack", 32'(masterAck), 32'h0);
        @(posedge clk); #1;
        sb.push_back('{3'b001, 3'b000, 32'h1111});
        slaveAck = 1'b1; slaveReadData = 32'h1111;
        @(posedge clk); #1;
        slaveAck = 1'b0; masterRequest[0] = 1'b0;
        @(negedge clk);
        check("prio_idle", 32'(slaveRequest), 32'h0);
        @(posedge clk); #1;
        sb.push_back('{3'b010, 3'b000, 32'h2222});
        slaveAck = 1'b1; slaveReadData = 32'h2222;
        @(negedge clk);
        check("prio_m1_before_m2", slaveAddress, 32'hA100);
        @(posedge clk); #1;
        slaveAck = 1'b0; masterRequest[1] = 1'b0;
        @(negedge clk);
        check("prio_idle2", 32'(slaveRequest), 32'h0);
        @(posedge clk); #1;
        sb.push_back('{3'b100, 3'b000, 32'h3333});
        slaveAck = 1'b1; slaveReadData = 32'h3333;
        @(negedge clk);
        check("prio_m2_last", slaveAddress, 32'hA200);
        @(posedge clk); #1;
        slaveAck = 1'b0; masterRequest[2] = 1'b0;
        @(posedge clk); #1;

        // Abort: owner drops its request before any ack
        set_master(0, 1'b0, 32'hB000, 32'h0);
        set_master(1, 1'b0, 32'hB100, 32'h0);
        masterRequest = 3'b011;
        @(posedge clk); #1;
        @(negedge clk);
        check("abort_busy_req", 32'(slaveRequest), 32'h1);
        check("abort_busy_addr", slaveAddress, 32'hB000);
        @(posedge clk); #1;
        masterRequest[0] = 1'b0;
        #1;
        check("abort_req_drop", 32'(slaveRequest), 32'h0);
        check("abort_no_ack", 32'(masterAck), 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        check("abort_idle", 32'(slaveRequest), 32'h0);
        @(posedge clk); #1;
        sb.push_back('{3'b010, 3'b000, 32'h4444});
        slaveAck = 1'b1; slaveReadData = 32'h4444;
        @(negedge clk);
        check("abort_next_grant", slaveAddress, 32'hB100);
        @(posedge clk); #1;
        slaveAck = 1'b0; masterRequest = '0;
        @(posedge clk); #1;

        // Reset mid-BUSY clears outputs without a clock edge
        set_master(1, 1'b1, 32'hC100, 32'hC0DE);
        masterRequest[1] = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_busy_req", 32'(slaveRequest), 32'h1);
        @(posedge clk); #1;
        slaveAck = 1'b1; slaveReadData = 32'h9999;
        reset = 1'b1;
        #1;
        check("rst_async_req", 32'(slaveRequest), 32'h0);
        check("rst_async_ack", 32'(masterAck), 32'h0);
        check("rst_async_err", 32'(masterError), 32'h0);
        check("rst_async_rdata", masterReadData, 32'h0);
        @(posedge clk); #1;
        slaveAck = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_release_idle", 32'(slaveRequest), 32'h0);
        @(posedge clk); #1;
        sb.push_back('{3'b010, 3'b000, 32'h5555});
        slaveAck = 1'b1; slaveReadData = 32'h5555;
        @(negedge clk);
        check("rst_regrant_req", 32'(slaveRequest), 32'h1);
        check("rst_regrant_wdata", slaveWriteData, 32'hC0DE);
        @(posedge clk); #1;
        slaveAck = 1'b0; masterRequest = '0;
        @(posedge clk); #1;

        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
